apu_i2s_out: RTL and testbench

- Downstream consumer of the APU mixer output (`audio`, `audio_en`).
- Box-car averages the per-clock mixer samples over one I2S frame, which decimates to the I2S frame rate.
- Converts the average from offset-binary to two's complement.
- Serialises it as mono-duplicated standard (Philips) I2S for the board codec or HDMI audio bridge.
- Lives at the NES top level, next to the APU instance, in the same clock domain.

---
 rtl/apu_i2s_out.sv | 157 +++++++++++++++
 tb/tb_apu_i2s_out.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_i2s_out.sv
// APU mixer to I2S transmitter: box-car decimation to frame rate, offset-binary to
// two's complement, mono-duplicated Philips I2S. Define AUDIO_DCBLOCK_EN for a DC-blocking high-pass.
module apu_i2s_out #(
  parameter int AUDIO_DEPTH   = 16,
  parameter int BCLK_DIV_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AUDIO_DEPTH-1:0] audio,
  input  logic                   audio_en,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   sample_strobe,
  output logic [AUDIO_DEPTH-1:0] sample_o
);

  localparam int TW = BCLK_DIV_LOG2 + 7;
  localparam int AW = AUDIO_DEPTH + TW;
  localparam logic [AUDIO_DEPTH-1:0] MIDSCALE = {1'b1, {(AUDIO_DEPTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [AUDIO_DEPTH-1:0] sample_q, sample_d;
  logic                   strobe_q, strobe_d;
  logic                   lrclk_q, lrclk_d;
  logic                   sdata_q, sdata_d;

  logic                   wrap, fall;
  logic [5:0]             bidx_n;
  logic [AUDIO_DEPTH-1:0] x, avg, signed_avg;
  logic [AW-1:0]          acc_sum;
  logic [63:0]            word;

  assign wrap   = &tcnt_q;
  assign fall   = &tcnt_q[BCLK_DIV_LOG2:0];
  assign tcnt_d = tcnt_q + 1'b1;
  assign bidx_n = tcnt_d[TW-1 -: 6];

  assign x          = audio_en ? audio : MIDSCALE;
  assign acc_sum    = acc_q + {{TW{1'b0}}, x};
  assign avg        = acc_sum[AW-1 -: AUDIO_DEPTH];
  assign signed_avg = {~avg[AUDIO_DEPTH-1], avg[AUDIO_DEPTH-2:0]};
  // Slot 0 is the one-BCLK I2S delay, slots 1..AUDIO_DEPTH carry MSB..LSB.
  assign word       = {1'b0, sample_q, {(63-AUDIO_DEPTH){1'b0}}};

  always_comb begin
    acc_d = wrap ? '0 : acc_sum;
  end

`ifdef AUDIO_DCBLOCK_EN
  localparam int YW = AUDIO_DEPTH + 2;

  logic signed [YW-1:0]   y_q, y_d, y_shr, y_next;
  logic [AUDIO_DEPTH-1:0] xprev_q, xprev_d;
  logic                   pend_q, pend_d;
  logic [AUDIO_DEPTH-1:0] y_sat;

  // y_shr kept separate so the >>> stays arithmetic regardless of the surrounding expression.
  assign y_shr  = y_q >>> 8;
  assign y_next = {{2{signed_avg[AUDIO_DEPTH-1]}}, signed_avg}
                - {{2{xprev_q[AUDIO_DEPTH-1]}}, xprev_q} + y_q - y_shr;

  always_comb begin
    if (y_q[YW-1:AUDIO_DEPTH-1] == '0 || y_q[YW-1:AUDIO_DEPTH-1] == '1)
      y_sat = y_q[AUDIO_DEPTH-1:0];
    else if (y_q[YW-1])
      y_sat = MIDSCALE;
    else
      y_sat = ~MIDSCALE;
  end

  always_comb begin
    y_d      = y_q;
    xprev_d  = xprev_q;
    pend_d   = 1'b0;
    sample_d = sample_q;
    strobe_d = 1'b0;
    if (wrap) begin
      y_d     = y_next;
      xprev_d = signed_avg;
      pend_d  = 1'b1;
    end
    if (pend_q) begin
      sample_d = y_sat;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      xprev_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      xprev_q <= xprev_d;
      pend_q  <= pend_d;
    end
  end
`else
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sample_d = sample_q;
    strobe_d = 1'b0;
    if (wrap) begin
      sample_d = signed_avg;
      strobe_d = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    if (wrap)
      state_d = S_LEFT;
    else if (fall && state_q != S_IDLE)
      state_d = bidx_n[5] ? S_RIGHT : S_LEFT;
    if (fall && state_d != S_IDLE) begin
      lrclk_d = (state_d == S_RIGHT);
      sdata_d = word[6'd63 - {1'b0, bidx_n[4:0]}];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values; = here would order-couple them.
    if (rst) begin
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      strobe_q <= strobe_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
    end
  end

  assign i2s_bclk      = tcnt_q[BCLK_DIV_LOG2];
  assign i2s_lrclk     = lrclk_q;
  assign i2s_sdata     = sdata_q;
  assign sample_strobe = strobe_q;
  assign sample_o      = sample_q;

endmodule

// File: tb/tb_apu_i2s_out.sv
// Self-checking bench for apu_i2s_out (default build): frame-average scoreboard plus
// per-clock checks of BCLK, LRCLK, SDATA and strobe timing against a behavioural model.
module tb_apu_i2s_out;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] audio = 16'h0000;
  logic        audio_en = 1'b0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe;
  logic [15:0] sample_o;

  int checks = 0;
  int errors = 0;

  int          tb_cnt  = 0;
  bit          started = 1'b0;
  longint      acc     = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cur_tx  = 16'h0000;

  apu_i2s_out #(.AUDIO_DEPTH(16), .BCLK_DIV_LOG2(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .audio        (audio),
    .audio_en     (audio_en),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .sample_strobe(sample_strobe),
    .sample_o     (sample_o)
  );

  always #5 clk = ~clk;

  // Model: accumulate the mapped input each clk, push the converted average at every 512th clk.
  always @(posedge clk) begin : model
    logic [15:0] xin;
    logic [15:0] avg;
    if (rst) begin
      tb_cnt  = 0;
      acc     = 0;
      started = 1'b1;
      exp_q.delete();
    end else if (started) begin
      xin = audio_en ? audio : 16'h8000;
      acc = acc + longint'(xin);
      tb_cnt++;
      if (tb_cnt % 512 == 0) begin
        avg = 16'(acc >> 9);
        exp_q.push_back({~avg[15], avg[14:0]});
        acc = 0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    int       t;
    bit       idle, exp_strobe, exp_bclk, exp_lr, exp_sd;
    int       slot;
    if (started) begin
      t          = tb_cnt % 512;
      idle       = (tb_cnt < 512);
      exp_strobe = (tb_cnt > 0) && (t == 0);
      exp_bclk   = t[2];
      exp_lr     = idle ? 1'b0 : t[8];
      if (exp_strobe) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty at cnt %0d", tb_cnt);
        end else begin
          cur_tx = exp_q.pop_front();
          if (sample_o !== cur_tx) begin
            errors++;
            $display("FAIL sample_o at cnt %0d: got %h expected %h", tb_cnt, sample_o, cur_tx);
          end
        end
      end
      slot   = (t >> 3) % 32;
      exp_sd = 1'b0;
      if (!idle && slot >= 1 && slot <= 16) exp_sd = cur_tx[16-slot];

      checks++;
      if (sample_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL strobe at cnt %0d: got %b expected %b", tb_cnt, sample_strobe, exp_strobe);
      end
      checks++;
      if (i2s_bclk !== exp_bclk) begin
        errors++;
        $display("FAIL bclk at cnt %0d: got %b expected %b", tb_cnt, i2s_bclk, exp_bclk);
      end
      checks++;
      if (i2s_lrclk !== exp_lr) begin
        errors++;
        $display("FAIL lrclk at cnt %0d: got %b expected %b", tb_cnt, i2s_lrclk, exp_lr);
      end
      checks++;
      if (i2s_sdata !== exp_sd) begin
        errors++;
        $display("FAIL sdata at cnt %0d: got %b expected %b", tb_cnt, i2s_sdata, exp_sd);
      end
    end
  end

  task automatic wait_boundary();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tb_cnt % 512 != 0) && n < 600);
    checks++;
    if (tb_cnt % 512 != 0) begin
      errors++;
      $display("FAIL boundary_timeout: cnt %0d", tb_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (i2s_bclk !== 1'b0)      begin errors++; $display("FAIL reset_bclk: got %b expected 0", i2s_bclk); end
    checks++;
    if (i2s_lrclk !== 1'b0)     begin errors++; $display("FAIL reset_lrclk: got %b expected 0", i2s_lrclk); end
    checks++;
    if (i2s_sdata !== 1'b0)     begin errors++; $display("FAIL reset_sdata: got %b expected 0", i2s_sdata); end
    checks++;
    if (sample_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", sample_strobe); end
    checks++;
    if (sample_o !== 16'h0000)  begin errors++; $display("FAIL reset_sample: got %h expected 0000", sample_o); end
    rst = 1'b0;
  endtask

  task automatic test_constant(input logic [15:0] a, input logic en, input int frames,
                               input logic [15:0] exp_s, input string name);
    wait_boundary();
    audio    = a;
    audio_en = en;
    repeat (frames * 512) @(negedge clk);
    checks++;
    if (sample_o !== exp_s) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, sample_o, exp_s);
    end
  endtask

  task automatic test_alternating();
    wait_boundary();
    audio_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      audio = i[0] ? 16'hFFFE : 16'h0000;
      @(negedge clk);
    end
    checks++;
    if (sample_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL alternating: got %h expected ffff", sample_o);
    end
  endtask

  task automatic test_random();
    wait_boundary();
    repeat (1024) begin
      audio    = 16'($urandom);
      audio_en = ($urandom_range(0, 7) != 0);
      @(negedge clk);
    end
    audio    = 16'h0000;
    audio_en = 1'b1;
    repeat (600) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: %0d expected samples never consumed", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    audio    = 16'hC000;
    audio_en = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(tb_cnt >= 512 && (tb_cnt % 512) / 8 == 20) && n < 1100);
    checks++;
    if (i2s_lrclk !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_slot: lrclk got %b expected 0 at bit 20", i2s_lrclk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe} !== 4'b0000 || sample_o !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b%b%b%b %h expected 0000 0000",
               i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe, sample_o);
    end
    rst = 1'b0;
    repeat (320) @(negedge clk);
    checks++;
    if (i2s_lrclk !== 1'b0 || i2s_sdata !== 1'b0) begin
      errors++;
      $display("FAIL idle_frame: lrclk %b sdata %b expected 0 0", i2s_lrclk, i2s_sdata);
    end
    repeat (704) @(negedge clk);
    checks++;
    if (sample_o !== 16'h4000) begin
      errors++;
      $display("FAIL post_reset_sample: got %h expected 4000", sample_o);
    end
  endtask

  initial begin
    test_reset();
    test_constant(16'hC000, 1'b1, 2, 16'h4000, "constant_c000");
    test_constant(16'hFFFF, 1'b0, 1, 16'h0000, "disabled_midscale");
    test_alternating();
    test_constant(16'hFFFF, 1'b1, 1, 16'h7FFF, "full_scale");
    test_constant(16'h0000, 1'b1, 1, 16'h8000, "silence_floor");
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
